stream_rr_merge: RTL and testbench
==================================

Name: stream_rr_merge

Overview:
- 2-to-1 AXI-stream merge that sits directly downstream of stream_demux.
- Re-joins the b and c branches into a single stream d.
- Arbitration is round-robin, packet-aware: a grant is held from the first beat to the beat with last=1.
- Output is fully registered, sustains 1 beat/cycle, and tags each beat with its source branch.

Parameters:
DATA_WD  32  width of the data bus on b, c and d

Ports:
clk      input   1        clock, all logic on rising edge
rstn     input   1        asynchronous reset, ACTIVE-HIGH (rstn=1 resets; the name is kept, the polarity is fixed as active-high)
b_data   input   DATA_WD  branch b data
b_valid  input   1        branch b valid
b_last   input   1        branch b last beat of packet
b_ready  output  1        branch b ready
c_data   input   DATA_WD  branch c data
c_valid  input   1        branch c valid
c_last   input   1        branch c last beat of packet
c_ready  output  1        branch c ready
d_data   output  DATA_WD  merged data (registered)
d_valid  output  1        merged valid (registered)
d_last   output  1        merged last (registered)
d_src    output  1        source of the current d beat: 0=b, 1=c (registered)
d_ready  input   1        downstream ready

Behaviour:
- Reset, asynchronous, while rstn=1:
  - d_valid=0, d_data=0, d_last=0, d_src=0.
  - lock=0, lock_src=0, prio=0 (b preferred first).
- Fires: b_fire=b_valid&b_ready, c_fire=c_valid&c_ready, d_fire=d_valid&d_ready.
- Output register load enable: load = !d_valid | d_ready (combinational path from d_ready to b_ready/c_ready is permitted).
- Grant selection (combinational), gnt in {none,b,c}:
  - lock=1: gnt=lock_src, even if that input's valid is low. The other input waits.
  - lock=0, only one input valid: gnt is that input.
  - lock=0, both valid: gnt=b if prio=0, else c.
  - lock=0, neither valid: gnt=none.
- Readies:
  - b_ready = load & (gnt==b).
  - c_ready = load & (gnt==c).
  - Never both 1 in the same cycle.
- On an accepted input beat (b_fire or c_fire):
  - d_data, d_last and d_src take the granted input's data, last and id.
  - d_valid=1.
- If load=1 and no input fires: d_valid becomes 0. d_data, d_last and d_src hold their values.
- While d_valid=1 and d_ready=0: d_data, d_last and d_src stay stable and no input is accepted.
- Lock FSM, states UNLOCKED and LOCKED(src):
  - UNLOCKED -> LOCKED(x): beat from x accepted with last=0.
  - LOCKED(x) -> UNLOCKED: beat from x accepted with last=1.
  - Single-beat packet (last=1 on first beat): state stays UNLOCKED.
- Priority update: on an accepted beat with last=1 from x, prio points to the other input (prio=1 after b, 0 after c). prio does not change on other beats.
- Timing: latency 1 cycle from input fire to d_valid. Throughput 1 beat/cycle with d_ready held 1, including back-to-back packets that switch source.
- Packets are never interleaved on d: all beats of a packet are contiguous and share d_src.
- Reset mid-packet clears lock and the output register immediately. The partial packet is dropped from d and the upstream must restart it.
- Width: no arithmetic. Data is passed bit-exact.

Test Plan:
- Reset, then b only: b sends 3 single-beat packets (data 0x1,0x2,0x3, last=1), d_ready=1 -> d_data 0x1,0x2,0x3 on consecutive cycles, d_src=0, d_valid rises 1 cycle after each b_fire.
- Contention, single beats: b and c both valid continuously with last=1 (b data 0x10.., c data 0x20..) -> d alternates b,c,b,c starting with b. d_src sequence 0,1,0,1. Zero idle cycles.
- Packet lock: b sends a 4-beat packet (0xA0..0xA3, last on 0xA3) while c is continuously valid with 0xC0 -> d carries all four A beats contiguously with d_src=0, then 0xC0. c_ready=0 throughout the b packet, even during a b_valid gap mid-packet.
- Backpressure: d_ready random (~50%) with both sources streaming random packets 1–5 beats -> d_data stable while d_valid&!d_ready. Every sent beat appears exactly once, in per-source order. No interleaving. b_ready&c_ready never both 1.
- Demux loopback: stream_demux output b/c feeding this block, random b/c/d readies, incrementing a_data, a_last=1 -> every a_data value appears on d exactly once. Ordering is preserved within each d_src.
- Reset mid-packet: rstn=1 for one cycle after beat 2 of a 4-beat c packet -> d_valid=0 and both readies 0 during reset. After release, b is granted first when both are valid, and no lock is left over.

Source files
------------

// File: rtl/stream_rr_merge.sv
// stream_rr_merge: packet-aware round-robin 2:1 AXI-stream merge with a registered output tagged by source.
module stream_rr_merge #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DATA_WD-1:0] b_data,
    input  logic               b_valid,
    input  logic               b_last,
    output logic               b_ready,
    input  logic [DATA_WD-1:0] c_data,
    input  logic               c_valid,
    input  logic               c_last,
    output logic               c_ready,
    output logic [DATA_WD-1:0] d_data,
    output logic               d_valid,
    output logic               d_last,
    output logic               d_src,
    input  logic               d_ready
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t state, state_n;
    logic lock_src, lock_src_n, prio;
    logic load, gnt_b, gnt_c, b_fire, c_fire, fire, in_last;
    assign load    = !d_valid | d_ready;
    assign gnt_b   = (state == LOCKED) ? !lock_src : b_valid & (!c_valid | !prio);
    assign gnt_c   = (state == LOCKED) ? lock_src : c_valid & (!b_valid | prio);
    // readies are held low while reset is asserted so nothing is taken upstream
    assign b_ready = load & gnt_b & !rstn;
    assign c_ready = load & gnt_c & !rstn;
    assign b_fire  = b_valid & b_ready;
    assign c_fire  = c_valid & c_ready;
    assign fire    = b_fire | c_fire;
    assign in_last = c_fire ? c_last : b_last;
    always_comb begin
        state_n    = state;
        lock_src_n = lock_src;
        if (fire && state == UNLOCKED && !in_last) begin
            state_n    = LOCKED;
            lock_src_n = c_fire;
        end else if (fire && state == LOCKED && in_last) begin
            state_n    = UNLOCKED;
        end
    end
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= UNLOCKED;
            lock_src <= 1'b0;
            prio     <= 1'b0;
        end else begin
            state    <= state_n;
            lock_src <= lock_src_n;
            if (fire && in_last)
                prio <= !c_fire;
        end
    end
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            d_valid <= 1'b0;
            d_data  <= '0;
            d_last  <= 1'b0;
            d_src   <= 1'b0;
        end else if (fire) begin
            d_valid <= 1'b1;
            d_data  <= c_fire ? c_data : b_data;
            d_last  <= in_last;
            d_src   <= c_fire;
        end else if (load) begin
            d_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_rr_merge.sv
// tb_stream_rr_merge: directed and randomized checks of stream_rr_merge against a queue-based reference model.
module tb_stream_rr_merge;
    localparam int DW = 32;
    typedef logic [DW+1:0] ent_t;
    logic clk = 1'b0;
    logic rstn;
    logic [DW-1:0] b_data, c_data, d_data;
    logic b_valid, b_last, b_ready, c_valid, c_last, c_ready;
    logic d_valid, d_last, d_src, d_ready;

    stream_rr_merge #(.DATA_WD(DW)) dut (
        .clk(clk), .rstn(rstn),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .c_data(c_data), .c_valid(c_valid), .c_last(c_last), .c_ready(c_ready),
        .d_data(d_data), .d_valid(d_valid), .d_last(d_last), .d_src(d_src),
        .d_ready(d_ready)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, c_fires = 0;
    int rdy_pct = 100, gap_pct = 0;
    ent_t bq[$], cq[$];
    logic [DW:0] expb[$], expc[$];
    ent_t log_d[$];
    int log_c[$];
    logic b_fired = 0, c_fired = 0, prev_fire = 0, prev_stall = 0;
    logic in_pkt = 0, pkt_src = 0, cblk = 0;
    ent_t prev_beat;

    function automatic ent_t mk(logic src, logic last, logic [DW-1:0] data);
        return {src, last, data};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [DW:0] e;
        cyc++;
        b_fired = b_valid & b_ready;
        c_fired = c_valid & c_ready;
        if (rstn) begin
            check("rst_d_valid", 64'(d_valid), 64'(0));
            check("rst_d_data", 64'(d_data), 64'(0));
            check("rst_d_last", 64'(d_last), 64'(0));
            check("rst_d_src", 64'(d_src), 64'(0));
            check("rst_readies", 64'({b_ready, c_ready}), 64'(0));
            expb.delete(); expc.delete();
            in_pkt = 0; prev_fire = 0; prev_stall = 0; b_fired = 0; c_fired = 0;
            return;
        end
        check("ready_exclusive", 64'(b_ready & c_ready), 64'(0));
        if (cblk) check("c_blocked", 64'(c_ready), 64'(0));
        if (prev_fire || prev_stall) begin
            check("d_valid_held", 64'(d_valid), 64'(1));
            check("d_beat", 64'({d_src, d_last, d_data}), 64'(prev_beat));
        end
        if (d_valid && d_ready) begin
            check("beat_pending", 64'(d_src ? expc.size() != 0 : expb.size() != 0), 64'(1));
            if (d_src ? expc.size() != 0 : expb.size() != 0) begin
                if (d_src) e = expc.pop_front();
                else e = expb.pop_front();
                check("per_src_order", 64'({d_last, d_data}), 64'(e));
            end
            if (in_pkt) check("no_interleave", 64'(d_src), 64'(pkt_src));
            in_pkt = !d_last;
            pkt_src = d_src;
            log_d.push_back(mk(d_src, d_last, d_data));
            log_c.push_back(cyc);
        end
        if (b_fired) begin
            expb.push_back({b_last, b_data});
            if (b_last) cblk = 0;
        end
        if (c_fired) begin
            expc.push_back({c_last, c_data});
            c_fires++;
        end
        prev_fire  = b_fired | c_fired;
        prev_stall = d_valid & !d_ready;
        prev_beat  = c_fired ? mk(1'b1, c_last, c_data) : b_fired ? mk(1'b0, b_last, b_data) : mk(d_src, d_last, d_data);
    endtask

    task automatic drive();
        if (b_fired) void'(bq.pop_front());
        if (!(b_valid && !b_fired)) begin
            if (bq.size() != 0 && bq[0][DW+1]) begin
                void'(bq.pop_front());
                b_valid = 0;
            end else if (bq.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
                b_valid = 1; b_last = bq[0][DW]; b_data = bq[0][DW-1:0];
            end else b_valid = 0;
        end
        if (c_fired) void'(cq.pop_front());
        if (!(c_valid && !c_fired)) begin
            if (cq.size() != 0 && cq[0][DW+1]) begin
                void'(cq.pop_front());
                c_valid = 0;
            end else if (cq.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
                c_valid = 1; c_last = cq[0][DW]; c_data = cq[0][DW-1:0];
            end else c_valid = 0;
        end
        d_ready = int'($urandom_range(99)) < rdy_pct;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(int maxc);
        int n = 0;
        while (!(bq.size() == 0 && cq.size() == 0 && !b_valid && !c_valid && !d_valid) && n < maxc) begin
            step();
            n++;
        end
        check("drained_in_time", 64'(n < maxc), 64'(1));
        check("model_empty", 64'(expb.size() + expc.size()), 64'(0));
    endtask

    task automatic do_reset();
        rstn = 1; b_valid = 0; c_valid = 0; cblk = 0;
        bq.delete(); cq.delete();
        repeat (2) step();
        rstn = 0;
        log_d.delete(); log_c.delete();
    endtask

    task automatic check_log(string tag, input ent_t e[$], input bit consec);
        check({tag, "_len"}, 64'(log_d.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < log_d.size(); i++) begin
            check(tag, 64'(log_d[i]), 64'(e[i]));
            if (consec && i > 0) check({tag, "_idle"}, 64'(log_c[i] - log_c[i-1]), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t ex[$];
        int seen[60];
        int n;
        rstn = 0; b_valid = 0; c_valid = 0; b_last = 0; c_last = 0;
        b_data = '0; c_data = '0; d_ready = 0;
        #2;
        // b alone, three single-beat packets
        rdy_pct = 100; gap_pct = 0;
        do_reset();
        for (int i = 1; i <= 3; i++) bq.push_back({2'b01, DW'(i)});
        run(50);
        ex.delete();
        for (int i = 1; i <= 3; i++) ex.push_back(mk(1'b0, 1'b1, DW'(i)));
        check_log("b_only", ex, 1);
        // contention between single beats alternates starting with b
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bq.push_back({2'b01, DW'(32'h10 + i)});
            cq.push_back({2'b01, DW'(32'h20 + i)});
        end
        run(50);
        ex.delete();
        for (int i = 0; i < 4; i++) begin
            ex.push_back(mk(1'b0, 1'b1, DW'(32'h10 + i)));
            ex.push_back(mk(1'b1, 1'b1, DW'(32'h20 + i)));
        end
        check_log("alternate", ex, 1);
        // b packet with a mid-packet valid gap holds the grant against c
        do_reset();
        bq.push_back({2'b00, DW'(32'hA0)});
        bq.push_back({2'b00, DW'(32'hA1)});
        bq.push_back({2'b10, DW'(0)});
        bq.push_back({2'b00, DW'(32'hA2)});
        bq.push_back({2'b01, DW'(32'hA3)});
        cq.push_back({2'b01, DW'(32'hC0)});
        cblk = 1;
        run(50);
        ex.delete();
        for (int i = 0; i < 4; i++) ex.push_back(mk(1'b0, i == 3, DW'(32'hA0 + i)));
        ex.push_back(mk(1'b1, 1'b1, DW'(32'hC0)));
        check_log("packet_lock", ex, 0);
        // random packets under random backpressure
        do_reset();
        rdy_pct = 50; gap_pct = 30;
        for (int p = 0; p < 30; p++) begin
            n = int'($urandom_range(5, 1));
            for (int k = 0; k < n; k++) bq.push_back({1'b0, k == n - 1, DW'($urandom())});
            n = int'($urandom_range(5, 1));
            for (int k = 0; k < n; k++) cq.push_back({1'b0, k == n - 1, DW'($urandom())});
        end
        run(5000);
        // incrementing stream split randomly over b and c, as a demux would
        do_reset();
        rdy_pct = 60; gap_pct = 40;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1) == 1) bq.push_back({2'b01, DW'(i)});
            else cq.push_back({2'b01, DW'(i)});
        end
        run(3000);
        foreach (seen[i]) seen[i] = 0;
        foreach (log_d[i]) if (log_d[i][DW-1:0] < 60) seen[log_d[i][DW-1:0]]++;
        foreach (seen[i]) check("loopback_once", 64'(seen[i]), 64'(1));
        // reset in the middle of a c packet
        rdy_pct = 100; gap_pct = 0;
        do_reset();
        c_fires = 0;
        for (int i = 0; i < 4; i++) cq.push_back({1'b0, i == 3, DW'(32'hC0 + i)});
        n = 0;
        while (c_fires < 2 && n < 50) begin
            step();
            n++;
        end
        check("c_two_beats", 64'(n < 50), 64'(1));
        rstn = 1;
        step();
        rstn = 0;
        cq.delete(); c_valid = 0;
        log_d.delete(); log_c.delete();
        bq.push_back({2'b01, DW'(32'hB0)});
        cq.push_back({2'b01, DW'(32'hD0)});
        run(50);
        ex.delete();
        ex.push_back(mk(1'b0, 1'b1, DW'(32'hB0)));
        ex.push_back(mk(1'b1, 1'b1, DW'(32'hD0)));
        check_log("after_reset", ex, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
